// File: rtl/mmio_arbiter_if.sv
// Two-port requester side plus shared register bus of the MMIO arbiter.
// master = requesters and register bank, slave = arbiter.
interface mmio_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [15:0] rdata0;
  logic [15:0] rdata1;
  logic [15:0] mem_addr;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_addr, mem_wr_en, mem_rd_en, mem_wdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_addr, mem_wr_en, mem_rd_en, mem_wdata, busy
  );
endinterface

// File: rtl/mmio_arbiter.sv
// Two-port MMIO arbiter onto a shared register bus; ack 2 cycles after sampling for writes, 3 for reads.
// One transaction in flight; requesters hold req until ack, the loser simply waits for a later IDLE.
module mmio_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mmio_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_port;
  logic        r_we;
  logic [15:0] r_addr;
  logic        r_last_grant;
  logic        r_ack0;
  logic        r_ack1;
  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;
  logic [15:0] r_mem_addr;
  logic        r_mem_wr_en;
  logic        r_mem_rd_en;
  logic [15:0] r_mem_wdata;
  logic        r_busy;

  logic        w_grant;
  logic        w_sel_we;
  logic [15:0] w_sel_addr;
  logic [15:0] w_sel_wdata;
  logic        w_latch;
  logic        w_capture;
  logic        w_ack0_nxt;
  logic        w_ack1_nxt;
  logic [15:0] w_mem_addr_nxt;
  logic        w_mem_wr_en_nxt;
  logic        w_mem_rd_en_nxt;
  logic [15:0] w_mem_wdata_nxt;

  // On a tie, round-robin hands the grant to whichever port did not win last time.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      w_grant = (FIXED_PRIO != 0) ? 1'b0 : !r_last_grant;
    end else begin
      w_grant = bus.req1;
    end
    w_sel_we    = w_grant ? bus.we1    : bus.we0;
    w_sel_addr  = w_grant ? bus.addr1  : bus.addr0;
    w_sel_wdata = w_grant ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_latch         = 1'b0;
    w_capture       = 1'b0;
    w_ack0_nxt      = 1'b0;
    w_ack1_nxt      = 1'b0;
    w_mem_addr_nxt  = 16'h0000;
    w_mem_wr_en_nxt = 1'b0;
    w_mem_rd_en_nxt = 1'b0;
    w_mem_wdata_nxt = 16'h0000;
    case (r_state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_latch         = 1'b1;
          w_state_nxt     = ISSUE;
          w_mem_addr_nxt  = w_sel_addr;
          w_mem_wr_en_nxt = w_sel_we;
          w_mem_rd_en_nxt = !w_sel_we;
          w_mem_wdata_nxt = w_sel_we ? w_sel_wdata : 16'h0000;
        end
      end
      ISSUE: begin
        if (r_we) begin
          w_state_nxt = ACK;
          w_ack0_nxt  = !r_port;
          w_ack1_nxt  = r_port;
        end else begin
          w_state_nxt    = RDWAIT;
          w_mem_addr_nxt = r_addr;
        end
      end
      RDWAIT: begin
        w_state_nxt = ACK;
        w_capture   = 1'b1;
        w_ack0_nxt  = !r_port;
        w_ack1_nxt  = r_port;
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are computed one state ahead so every port is driven straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 16'h0000;
      r_last_grant <= 1'b1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= 16'h0000;
      r_rdata1     <= 16'h0000;
      r_mem_addr   <= 16'h0000;
      r_mem_wr_en  <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_mem_wdata  <= 16'h0000;
      r_busy       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack0      <= w_ack0_nxt;
      r_ack1      <= w_ack1_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wr_en <= w_mem_wr_en_nxt;
      r_mem_rd_en <= w_mem_rd_en_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      if (w_latch) begin
        r_port       <= w_grant;
        r_we         <= w_sel_we;
        r_addr       <= w_sel_addr;
        r_last_grant <= w_grant;
      end
      if (w_capture) begin
        if (r_port) begin
          r_rdata1 <= bus.mem_rdata;
        end else begin
          r_rdata0 <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wr_en = r_mem_wr_en;
  assign bus.mem_rd_en = r_mem_rd_en;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: round-robin and fixed-priority instances against a transaction-level model.
module tb_mmio_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmio_arbiter_if if0 ();
  mmio_arbiter_if if1 ();

  mmio_arbiter #(.FIXED_PRIO(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mmio_arbiter #(.FIXED_PRIO(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int checks = 0;
  int errors = 0;

  // Register bank behind dut0: 256 mapped registers, not reset, registered read data.
  logic [15:0] regs [0:255] = '{default: 16'h0000};
  logic [15:0] rd_q = 16'h0000;
  always @(posedge clk) begin
    if (if0.mem_wr_en && if0.mem_addr < 16'd256) regs[if0.mem_addr[7:0]] <= if0.mem_wdata;
    rd_q <= (if0.mem_rd_en && if0.mem_addr < 16'd256) ? regs[if0.mem_addr[7:0]] : 16'h0000;
  end
  assign if0.mem_rdata = rd_q;
  assign if1.mem_rdata = 16'h0000;

  // Reference state: register contents, per-port read results, last granted port.
  logic [15:0] ref_mem [0:255] = '{default: 16'h0000};
  logic [15:0] ref_rdata [2];
  int          exp_last;
  logic        p_req [2];
  logic        p_we [2];
  logic [15:0] p_addr [2];
  logic [15:0] p_wdata [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    chk("ack_overlap_rr", 16'(if0.ack0 & if0.ack1), 16'h0000);
    chk("ack_overlap_fp", 16'(if1.ack0 & if1.ack1), 16'h0000);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    if0.req0 = p_req[0];   if0.req1 = p_req[1];
    if0.we0 = p_we[0];     if0.we1 = p_we[1];
    if0.addr0 = p_addr[0]; if0.addr1 = p_addr[1];
    if0.wdata0 = p_wdata[0]; if0.wdata1 = p_wdata[1];
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d);
    p_req[p] = r; p_we[p] = w; p_addr[p] = a; p_wdata[p] = d;
    drive();
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return (a < 16'd256) ? ref_mem[a[7:0]] : 16'h0000;
  endfunction

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_addr"}, if0.mem_addr, 16'h0000);
    chk({tag, "_strb"}, 16'({if0.mem_wr_en, if0.mem_rd_en}), 16'h0000);
    chk({tag, "_wdata"}, if0.mem_wdata, 16'h0000);
  endtask

  task automatic idle_cycle();
    chk("idle_busy", 16'(if0.busy), 16'h0000);
    chk("idle_ack", 16'({if0.ack1, if0.ack0}), 16'h0000);
    tick();
  endtask

  // Entered with dut0 in IDLE; runs one whole transaction and drops the winner's req after ack.
  task automatic run_txn(output int win);
    logic [15:0] a;
    logic        w;
    chk("idle_busy", 16'(if0.busy), 16'h0000);
    chk("idle_ack", 16'({if0.ack1, if0.ack0}), 16'h0000);
    chk_bus_idle("idle");
    if (p_req[0] && p_req[1]) win = 1 - exp_last;
    else                      win = p_req[1] ? 1 : 0;
    exp_last = win;
    a = p_addr[win];
    w = p_we[win];
    tick();
    chk("issue_wr", 16'(if0.mem_wr_en), 16'(w));
    chk("issue_rd", 16'(if0.mem_rd_en), 16'(!w));
    chk("issue_addr", if0.mem_addr, a);
    chk("issue_wdata", if0.mem_wdata, w ? p_wdata[win] : 16'h0000);
    chk("issue_busy", 16'(if0.busy), 16'h0001);
    chk("issue_ack", 16'({if0.ack1, if0.ack0}), 16'h0000);
    if (w && a < 16'd256) ref_mem[a[7:0]] = p_wdata[win];
    tick();
    if (!w) begin
      chk("rdwait_strb", 16'({if0.mem_wr_en, if0.mem_rd_en}), 16'h0000);
      chk("rdwait_addr", if0.mem_addr, a);
      chk("rdwait_ack", 16'({if0.ack1, if0.ack0}), 16'h0000);
      chk("rdwait_busy", 16'(if0.busy), 16'h0001);
      ref_rdata[win] = ref_read(a);
      tick();
    end
    chk("ack_pattern", 16'({if0.ack1, if0.ack0}), (win == 1) ? 16'h0002 : 16'h0001);
    chk("ack_busy", 16'(if0.busy), 16'h0001);
    chk_bus_idle("ack");
    chk("ack_rdata0", if0.rdata0, ref_rdata[0]);
    chk("ack_rdata1", if0.rdata1, ref_rdata[1]);
    tick();
    p_req[win] = 1'b0;
    drive();
  endtask

  initial begin
    int          win;
    logic [15:0] ra;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = 16'h0000; p_wdata[p] = 16'h0000;
      ref_rdata[p] = 16'h0000;
    end
    exp_last = 1;
    drive();
    if1.req0 = 1'b0; if1.req1 = 1'b0; if1.we0 = 1'b0; if1.we1 = 1'b0;
    if1.addr0 = 16'h0000; if1.addr1 = 16'h0000; if1.wdata0 = 16'h0000; if1.wdata1 = 16'h0000;

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", 16'(if0.busy), 16'h0000);
    chk("rst_ack", 16'({if0.ack1, if0.ack0}), 16'h0000);
    chk("rst_rdata0", if0.rdata0, 16'h0000);
    chk("rst_rdata1", if0.rdata1, 16'h0000);
    chk_bus_idle("rst");
    chk("rst_fp_busy", 16'(if1.busy), 16'h0000);
    rst_n = 1'b1;
    tick();

    // Directed write then read-back of the same register.
    set_port(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    run_txn(win);
    chk("wr_beef_port", 16'(win), 16'h0000);
    set_port(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    run_txn(win);
    chk("rd_beef_rdata1", if0.rdata1, 16'hBEEF);

    // Both ports requesting continuously: grants must alternate starting at port 0.
    set_port(0, 1'b1, 1'b1, 16'h0003, 16'hA000);
    set_port(1, 1'b1, 1'b1, 16'h0004, 16'hB000);
    for (int i = 0; i < 4; i++) begin
      run_txn(win);
      chk("rr_alternate", 16'(win), 16'(i % 2));
      set_port(win, 1'b1, 1'b1, 16'(win + 3), 16'(16'hC000 + i));
    end
    set_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Random traffic over a small mapped window plus occasional unmapped addresses.
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] && $urandom_range(0, 3) != 0) begin
          ra = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                           : 16'($urandom_range(0, 15));
          set_port(p, 1'b1, 1'($urandom_range(0, 1)), ra, 16'($urandom));
        end
      end
      if (p_req[0] || p_req[1]) run_txn(win);
      else                      idle_cycle();
    end
    while (p_req[0] || p_req[1]) run_txn(win);

    // Unmapped read returns zero.
    set_port(0, 1'b1, 1'b0, 16'h7FFF, 16'h0000);
    run_txn(win);
    chk("unmapped_rdata0", if0.rdata0, 16'h0000);

    // Reset on the edge ending a write's ISSUE: no ack, but the register still takes the data.
    set_port(0, 1'b1, 1'b1, 16'h0020, 16'h1234);
    tick();
    chk("rstw_issue_wr", 16'(if0.mem_wr_en), 16'h0001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstw_busy", 16'(if0.busy), 16'h0000);
    chk("rstw_ack", 16'({if0.ack1, if0.ack0}), 16'h0000);
    set_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    exp_last = 1;
    ref_rdata[0] = 16'h0000;
    ref_rdata[1] = 16'h0000;
    ref_mem[8'h20] = 16'h1234;
    set_port(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    run_txn(win);
    chk("rstw_landed", if0.rdata1, 16'h1234);

    // Reset during RDWAIT of a port 1 read aborts it and clears rdata1.
    set_port(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    tick();
    tick();
    chk("rstr_in_rdwait", 16'(if0.busy), 16'h0001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    exp_last = 1;
    ref_rdata[1] = 16'h0000;
    chk("rstr_busy", 16'(if0.busy), 16'h0000);
    chk("rstr_rdata1", if0.rdata1, 16'h0000);
    chk_bus_idle("rstr");
    for (int i = 0; i < 3; i++) begin
      chk("rstr_no_ack1", 16'(if0.ack1), 16'h0000);
      tick();
    end

    // Fixed priority: port 0 wins every tie while it keeps requesting.
    if1.we0 = 1'b1; if1.addr0 = 16'h0001; if1.wdata0 = 16'h1111;
    if1.we1 = 1'b1; if1.addr1 = 16'h0002; if1.wdata1 = 16'h2222;
    if1.req0 = 1'b1;
    if1.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      chk("fp_ack", 16'({if1.ack1, if1.ack0}), 16'h0001);
      tick();
    end
    if1.req0 = 1'b0;
    tick();
    tick();
    chk("fp_port1_ack", 16'({if1.ack1, if1.ack0}), 16'h0002);
    tick();
    if1.req1 = 1'b0;
    tick();
    chk("fp_idle_busy", 16'(if1.busy), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning: 0 = round-robin arbitration, 1 = port 0 always wins ties.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0, req1  input  1 each  transaction request from port 0 / port 1.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; valid while req high.
REQ-006 addr0, addr1  input  16 each  target register address.
REQ-007 wdata0, wdata1  input  16 each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse per port.
REQ-009 rdata0, rdata1  output  16 each  read result, valid only while matching ack is high.
REQ-010 mem_addr  output  16  shared register-bus address.
REQ-011 mem_wr_en, mem_rd_en  output  1 each  shared bus write/read strobes.
REQ-012 mem_wdata  output  16  shared bus write data, fanned out to every register's data_in.
REQ-013 mem_rdata  input  16  bitwise OR of all registers' data_out; unaddressed registers drive 0.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 FSM states SHALL be IDLE, ISSUE, RDWAIT, ACK.
REQ-017 IDLE: if req0|req1, select a winner, latch its addr/we/wdata and port id, go to ISSUE; else stay in IDLE.
REQ-018 Arbitration, only req0 high -> port 0; only req1 high -> port 1.
REQ-019 Arbitration, both high with FIXED_PRIO=1 -> port 0.
REQ-020 Arbitration, both high with FIXED_PRIO=0 -> port not recorded in last_grant; last_grant updates on every grant.
REQ-021 ISSUE (exactly 1 cycle): mem_addr = latched addr; mem_wr_en = we; mem_rd_en = !we; mem_wdata = wdata for writes, 0 for reads.
REQ-022 ISSUE exit: write -> ACK; read -> RDWAIT.
REQ-023 RDWAIT (exactly 1 cycle): mem_addr held at latched addr; both strobes 0; mem_rdata captured into the winning port's rdata at the end of the cycle.
REQ-024 ACK (exactly 1 cycle): winning port's ack = 1 and all bus outputs idle; then go to IDLE.
REQ-025 Bus idle values in IDLE and ACK: mem_addr = 0, mem_wr_en = 0, mem_rd_en = 0, mem_wdata = 0.
REQ-026 Latency from the IDLE cycle that samples req to ack high: write = 2 cycles, read = 3 cycles.
REQ-027 Only one transaction SHALL be outstanding; the losing request stays pending and is serviced in a later IDLE.
REQ-028 Requester SHALL hold req, we, addr and wdata stable until ack.
REQ-029 Requester SHALL drop req at the edge ending its ack cycle; req still high in the following IDLE is a new transaction.
REQ-030 rdataN SHALL hold its last value outside ack; it is 0 after reset; a write never changes it.
REQ-031 ack0 and ack1 SHALL never be high in the same cycle.
REQ-032 Port inputs sampled only in IDLE; changes in other states are ignored.

Reset
REQ-033 rst_n low at a posedge: state = IDLE, last_grant = 1 (port 0 wins the first tie), all outputs = 0, busy = 0.
REQ-034 Reset mid-transaction aborts it with no ack.
REQ-035 A write whose ISSUE cycle coincides with the reset edge still lands in the target register, because the registers are not reset; the requester must reissue after reset.
REQ-036 Reset has priority over every FSM transition.

Verification
REQ-037 req0 write addr=16'h0010, wdata=16'hBEEF -> mem_wr_en=1 with mem_addr=16'h0010, mem_wdata=16'hBEEF one cycle after the sampling edge; ack0 the next cycle.
REQ-038 req1 read addr=16'h0010 after REQ-037 -> mem_rd_en pulse; ack1 3 cycles after sampling; rdata1=16'hBEEF.
REQ-039 req0 and req1 high together continuously, FIXED_PRIO=0 -> grants alternate 0,1,0,1; no ack overlap; each port acked every other transaction.
REQ-040 Same stimulus with FIXED_PRIO=1 -> port 0 serviced while it holds req; port 1 granted only in the IDLE where req0 is low.
REQ-041 rst_n low during RDWAIT of a port 1 read -> next cycle IDLE, ack1 never asserts, rdata1=0, busy=0.
REQ-042 Single read of an unmapped addr=16'h7FFF -> ack after 3 cycles with rdata=16'h0000.
